// File: rtl/ff_excitation_driver.sv
// ff_excitation_driver: derives per-lane flip-flop excitation (SR/D/JK/T) from a
// desired next-state word, drives it for one clock edge, then checks the lanes'
// Q outputs against the target and counts failing checks.
// Optional feature: define JK_TOGGLE_EN to drive J=K=1 on JK lanes that change.
module ff_excitation_driver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             clr_cnt,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_q,
  input  logic [WIDTH-1:0] ff_q,
  output logic [WIDTH-1:0] exc_a,
  output logic [WIDTH-1:0] exc_b,
  output logic             done,
  output logic [WIDTH-1:0] err_mask,
  output logic [CNT_W-1:0] mismatch_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_D  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       mode_r_q, mode_r_d;
  logic [WIDTH-1:0] tgt_r_q, tgt_r_d;
  logic [WIDTH-1:0] exc_a_q, exc_a_d;
  logic [WIDTH-1:0] exc_b_q, exc_b_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] err_new;

  // Excitation {a, b} that moves each lane from cur to tgt for the given type.
  function automatic logic [2*WIDTH-1:0] excite(input logic [1:0] m,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] tgt);
    logic [WIDTH-1:0] a, b;
    a = '0;
    b = '0;
    case (m)
      MODE_SR: begin
        a = ~cur & tgt;
        b = cur & ~tgt;
      end
      MODE_D: a = tgt;
      MODE_JK: begin
`ifdef JK_TOGGLE_EN
        a = cur ^ tgt;
        b = cur ^ tgt;
`else
        a = ~cur & tgt;
        b = cur & ~tgt;
`endif
      end
      default: a = cur ^ tgt;
    endcase
    return {a, b};
  endfunction

  // Excitation that leaves the lanes where they are between transactions.
  function automatic logic [2*WIDTH-1:0] hold(input logic [1:0] m,
                                              input logic [WIDTH-1:0] tgt);
    return (m == MODE_D) ? {tgt, {WIDTH{1'b0}}} : {2*WIDTH{1'b0}};
  endfunction

  // Per-lane compare; an unknown Q bit falls through to the mismatch branch.
  function automatic logic [WIDTH-1:0] mismatch(input logic [WIDTH-1:0] tgt,
                                                input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] e;
    for (int i = 0; i < WIDTH; i++) begin
      if (q[i] == tgt[i]) e[i] = 1'b0;
      else                e[i] = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  assign err_new = mismatch(tgt_r_q, ff_q);

  // Next-state, excitation and check logic for the IDLE/DRIVE/CHECK sequence.
  always_comb begin
    state_d            = state_q;
    mode_r_d           = mode_r_q;
    tgt_r_d            = tgt_r_q;
    {exc_a_d, exc_b_d} = hold(mode_r_q, tgt_r_q);
    done_d             = 1'b0;
    err_d              = err_q;
    cnt_d              = cnt_q;
    case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          tgt_r_d            = tgt_q;
          mode_r_d           = mode;
          {exc_a_d, exc_b_d} = excite(mode, ff_q, tgt_q);
          state_d            = DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        err_d   = err_new;
        done_d  = 1'b1;
        if (err_new != '0) cnt_d = sat_inc(cnt_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr_cnt) cnt_d = '0;
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_r_q <= MODE_SR;
      tgt_r_q  <= '0;
      exc_a_q  <= '0;
      exc_b_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_r_q <= mode_r_d;
      tgt_r_q  <= tgt_r_d;
      exc_a_q  <= exc_a_d;
      exc_b_q  <= exc_b_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tgt_ready    = (state_q == IDLE);
  assign exc_a        = exc_a_q;
  assign exc_b        = exc_b_q;
  assign done         = done_q;
  assign err_mask     = err_q;
  assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Bench for ff_excitation_driver: behavioural flip-flop lanes plus a scoreboard
// of expected excitation and error masks pushed at each accepted target.
module tb_ff_excitation_driver;

  localparam logic [1:0] M_SR = 2'b00;
  localparam logic [1:0] M_D  = 2'b01;
  localparam logic [1:0] M_JK = 2'b10;
  localparam logic [1:0] M_T  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = M_D;
  logic       clr_cnt = 1'b0;
  logic       tgt_valid = 1'b0;
  logic       tgt_ready;
  logic [3:0] tgt_q = '0;
  logic [3:0] ff_q;
  logic [3:0] exc_a, exc_b, err_mask;
  logic       done;
  logic [7:0] mismatch_cnt;

  int tests = 0;
  int fails = 0;

  logic [3:0] lane_q = '0;
  logic [3:0] stuck = '0;
  logic [1:0] lane_mode = M_D;

  logic [3:0] exa_qu[$];
  logic [3:0] exb_qu[$];
  logic [3:0] err_qu[$];
  int         acc_cnt = 0;
  logic       d1 = 1'b0, d2 = 1'b0, done_exp = 1'b0;
  logic [7:0] cnt_m = '0;
  logic [7:0] exp_e;
  logic [3:0] pa, pb, pe;

  always #5 clk = ~clk;

  assign ff_q = lane_q & ~stuck;

  ff_excitation_driver #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .clr_cnt(clr_cnt),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_q(tgt_q), .ff_q(ff_q),
    .exc_a(exc_a), .exc_b(exc_b), .done(done), .err_mask(err_mask),
    .mismatch_cnt(mismatch_cnt)
  );

  // Expected {a,b} from the excitation table, lane by lane.
  function automatic logic [7:0] exp_exc(input logic [1:0] m, input logic [3:0] c,
                                         input logic [3:0] t);
    logic [3:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a[i] = 1'b0;
      b[i] = 1'b0;
      case (m)
        M_D: a[i] = t[i];
        M_T: a[i] = c[i] ^ t[i];
        M_JK: begin
`ifdef JK_TOGGLE_EN
          if (c[i] != t[i]) begin a[i] = 1'b1; b[i] = 1'b1; end
`else
          if (!c[i] && t[i]) a[i] = 1'b1;
          if (c[i] && !t[i]) b[i] = 1'b1;
`endif
        end
        default: begin
          if (!c[i] && t[i]) a[i] = 1'b1;
          if (c[i] && !t[i]) b[i] = 1'b1;
        end
      endcase
    end
    return {a, b};
  endfunction

  // Lanes respond to the excitation at the edge that closes DRIVE.
  always @(posedge clk) begin
    if (d1) begin
      for (int i = 0; i < 4; i++) begin
        case (lane_mode)
          M_SR: if (exc_a[i]) lane_q[i] <= 1'b1; else if (exc_b[i]) lane_q[i] <= 1'b0;
          M_D:  lane_q[i] <= exc_a[i];
          M_JK: begin
            if (exc_a[i] && exc_b[i]) lane_q[i] <= ~lane_q[i];
            else if (exc_a[i])        lane_q[i] <= 1'b1;
            else if (exc_b[i])        lane_q[i] <= 1'b0;
          end
          default: if (exc_a[i]) lane_q[i] <= ~lane_q[i];
        endcase
      end
    end
  end

  // Scoreboard producer and counter model, on the active edge.
  always @(posedge clk) begin
    if (rst) begin
      d1 <= 1'b0; d2 <= 1'b0; done_exp <= 1'b0; cnt_m <= '0;
      exa_qu.delete(); exb_qu.delete(); err_qu.delete();
    end else begin
      if (tgt_valid && tgt_ready) begin
        exp_e = exp_exc(mode, ff_q, tgt_q);
        exa_qu.push_back(exp_e[7:4]);
        exb_qu.push_back(exp_e[3:0]);
        err_qu.push_back(tgt_q & stuck);
        acc_cnt++;
      end
      d1 <= tgt_valid && tgt_ready;
      d2 <= d1;
      done_exp <= d2;
      if (clr_cnt) cnt_m <= '0;
      else if (d2 && err_qu.size() > 0 && err_qu[0] != 4'b0 && cnt_m != 8'hFF)
        cnt_m <= cnt_m + 8'd1;
    end
  end

  // Scoreboard consumer, away from the active edge.
  always @(negedge clk) begin
    if (d1) begin
      tests++;
      if (exa_qu.size() == 0) begin
        fails++; $display("FAIL exc_queue_empty: no expected excitation");
      end else begin
        pa = exa_qu.pop_front();
        pb = exb_qu.pop_front();
        if (exc_a !== pa || exc_b !== pb) begin
          fails++;
          $display("FAIL drive_exc: got a=%b b=%b, expected a=%b b=%b", exc_a, exc_b, pa, pb);
        end
      end
    end
    if (done || done_exp) begin
      tests++;
      if (done !== done_exp) begin
        fails++; $display("FAIL done_pulse: got %b, expected %b", done, done_exp);
      end
    end
    if (done && done_exp && err_qu.size() > 0) begin
      pe = err_qu.pop_front();
      tests++;
      if (err_mask !== pe) begin
        fails++; $display("FAIL err_mask: got %b, expected %b", err_mask, pe);
      end
      tests++;
      if (mismatch_cnt !== cnt_m) begin
        fails++; $display("FAIL mismatch_cnt: got %0d, expected %0d", mismatch_cnt, cnt_m);
      end
    end
  end

  task automatic txn(input logic [1:0] m, input logic [3:0] t);
    int w = 0;
    while (!tgt_ready && w < 20) begin @(negedge clk); w++; end
    tests++;
    if (!tgt_ready) begin fails++; $display("FAIL ready_timeout: tgt_ready=%b expected 1", tgt_ready); end
    lane_mode = m; mode = m; tgt_q = t; tgt_valid = 1'b1;
    @(negedge clk); tgt_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests += 6;
    if (tgt_ready !== 1'b1)  begin fails++; $display("FAIL rst_ready: got %b expected 1", tgt_ready); end
    if (exc_a !== 4'b0)      begin fails++; $display("FAIL rst_exc_a: got %b expected 0000", exc_a); end
    if (exc_b !== 4'b0)      begin fails++; $display("FAIL rst_exc_b: got %b expected 0000", exc_b); end
    if (done !== 1'b0)       begin fails++; $display("FAIL rst_done: got %b expected 0", done); end
    if (err_mask !== 4'b0)   begin fails++; $display("FAIL rst_err: got %b expected 0000", err_mask); end
    if (mismatch_cnt !== 0)  begin fails++; $display("FAIL rst_cnt: got %0d expected 0", mismatch_cnt); end
    rst = 1'b0;
    @(negedge clk);
    lane_mode = M_D; mode = M_D; tgt_q = 4'b0011; tgt_valid = 1'b1;
    @(negedge clk); tgt_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    tests += 2;
    if (tgt_ready !== 1'b1 || exc_a !== 4'b0) begin
      fails++; $display("FAIL abort_state: ready=%b exc_a=%b expected 1 0000", tgt_ready, exc_a);
    end
    if (done !== 1'b0) begin fails++; $display("FAIL abort_done: got %b expected 0", done); end
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL abort_late_done: got %b expected 0", done); end
    end
  endtask

  task automatic test_t_mode();
    txn(M_D, 4'b0000);
    txn(M_T, 4'b1010);
    tests++;
    if (done !== 1'b1 || err_mask !== 4'b0000) begin
      fails++; $display("FAIL t_mode_check: done=%b err=%b expected 1 0000", done, err_mask);
    end
  endtask

  task automatic test_sr_mode();
    txn(M_D, 4'b1100);
    txn(M_SR, 4'b0110);
    tests++;
    if (err_mask !== 4'b0000) begin fails++; $display("FAIL sr_check: err=%b expected 0000", err_mask); end
  endtask

  task automatic test_jk_mode();
    txn(M_D, 4'b0101);
    txn(M_JK, 4'b1001);
    tests++;
    if (err_mask !== 4'b0000) begin fails++; $display("FAIL jk_check: err=%b expected 0000", err_mask); end
  endtask

  task automatic test_stuck_lane();
    clr_cnt = 1'b1; @(negedge clk); clr_cnt = 1'b0;
    stuck = 4'b0001;
    txn(M_D, 4'b0001);
    tests += 2;
    if (err_mask !== 4'b0001) begin fails++; $display("FAIL stuck_err: got %b expected 0001", err_mask); end
    if (mismatch_cnt !== 8'd1) begin fails++; $display("FAIL stuck_cnt1: got %0d expected 1", mismatch_cnt); end
    repeat (255) txn(M_D, 4'b0001);
    tests++;
    if (mismatch_cnt !== 8'd255) begin fails++; $display("FAIL cnt_sat: got %0d expected 255", mismatch_cnt); end
    txn(M_D, 4'b0001);
    tests++;
    if (mismatch_cnt !== 8'd255) begin fails++; $display("FAIL cnt_hold_sat: got %0d expected 255", mismatch_cnt); end
    mode = M_D; tgt_q = 4'b0001; tgt_valid = 1'b1;
    @(negedge clk); tgt_valid = 1'b0;
    @(negedge clk); clr_cnt = 1'b1;
    @(negedge clk); clr_cnt = 1'b0;
    tests += 2;
    if (mismatch_cnt !== 8'd0) begin fails++; $display("FAIL clr_priority: got %0d expected 0", mismatch_cnt); end
    if (err_mask !== 4'b0001) begin fails++; $display("FAIL clr_err: got %b expected 0001", err_mask); end
    stuck = 4'b0000;
  endtask

  task automatic test_back_to_back();
    int a0;
    a0 = acc_cnt;
    lane_mode = M_D; mode = M_D; tgt_q = 4'($urandom); tgt_valid = 1'b1;
    repeat (9) begin
      @(negedge clk);
      tgt_q = 4'($urandom);
    end
    tgt_valid = 1'b0;
    tests++;
    if (acc_cnt - a0 != 3) begin fails++; $display("FAIL b2b_accepts: got %0d expected 3", acc_cnt - a0); end
    repeat (3) @(negedge clk);
    lane_mode = M_JK; mode = M_JK; tgt_q = ~ff_q | 4'b1000; tgt_valid = 1'b1;
    @(negedge clk); tgt_valid = 1'b0; mode = M_D;
    @(negedge clk);
    tests++;
    if (exc_a !== 4'b0 || exc_b !== 4'b0) begin
      fails++; $display("FAIL mode_change_hold: a=%b b=%b expected 0000 0000", exc_a, exc_b);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_t_mode();
    test_sr_mode();
    test_jk_mode();
    test_stuck_lane();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
